// File: rtl/peri_pkg.sv
// Shared types, constants and default parameter values for the peripheral register router.
package peri_pkg;

    localparam int unsigned PERI_NUM_SLV = 4;
    localparam int unsigned PERI_ADDR_W  = 11;
    localparam int unsigned PERI_SEL_W   = 4;
    localparam int unsigned PERI_TO_CYC  = 255;
    localparam int unsigned PERI_DATA_W  = 32;
    localparam int unsigned PERI_BE_W    = 4;

    // Read data returned to the master when a slave access times out
    localparam logic [PERI_DATA_W-1:0] PERI_TO_DATA = 32'hDEAD_DEAD;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } peri_state_e;

endpackage

// File: rtl/peri_wdog_cnt.sv
// Slave-access watchdog: counts cycles while enabled; expire is high once TO_CYC-1 is reached.
module peri_wdog_cnt
    import peri_pkg::*;
#(
    parameter int unsigned TO_CYC = PERI_TO_CYC
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int unsigned       CNT_W = 16;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TO_CYC - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin : cnt_next
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !expire) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q == LIMIT);

endmodule

// File: rtl/peri_reg_router.sv
// Routes one outstanding register access from a single master to one of NUM_SLV slaves.
// Optional slave timeout watchdog is built when PERI_TIMEOUT_EN is defined.
module peri_reg_router
    import peri_pkg::*;
#(
    parameter int unsigned NUM_SLV = PERI_NUM_SLV,
    parameter int unsigned ADDR_W  = PERI_ADDR_W,
    parameter int unsigned SEL_W   = PERI_SEL_W,
    parameter int unsigned TO_CYC  = PERI_TO_CYC
) (
    input  logic                           mclk,
    input  logic                           s_reset_n,
    input  logic                           reg_cs,
    input  logic                           reg_wr,
    input  logic [ADDR_W-1:0]              reg_addr,
    input  logic [PERI_DATA_W-1:0]         reg_wdata,
    input  logic [PERI_BE_W-1:0]           reg_be,
    output logic [PERI_DATA_W-1:0]         reg_rdata,
    output logic                           reg_ack,
    output logic                           reg_err,
    output logic [NUM_SLV-1:0]             slv_cs,
    output logic                           slv_wr,
    output logic [ADDR_W-SEL_W-1:0]        slv_addr,
    output logic [PERI_DATA_W-1:0]         slv_wdata,
    output logic [PERI_BE_W-1:0]           slv_be,
    input  logic [NUM_SLV*PERI_DATA_W-1:0] slv_rdata,
    input  logic [NUM_SLV-1:0]             slv_ack,
    output logic                           to_intr,
    output logic [SEL_W-1:0]               to_slv_id
);

    localparam int unsigned SUB_W = ADDR_W - SEL_W;

    if (NUM_SLV < 1 || NUM_SLV > 16 || TO_CYC < 1 || TO_CYC > 65535) begin : g_param_chk
        $error("peri_reg_router: NUM_SLV or TO_CYC out of range");
    end

    peri_state_e             state_q, state_d;
    logic [SEL_W-1:0]        idx_q, idx_d;
    logic [NUM_SLV-1:0]      slv_cs_q, slv_cs_d;
    logic                    slv_wr_q, slv_wr_d;
    logic [SUB_W-1:0]        slv_addr_q, slv_addr_d;
    logic [PERI_DATA_W-1:0]  slv_wdata_q, slv_wdata_d;
    logic [PERI_BE_W-1:0]    slv_be_q, slv_be_d;
    logic                    reg_ack_q, reg_ack_d;
    logic                    reg_err_q, reg_err_d;
    logic [PERI_DATA_W-1:0]  reg_rdata_q, reg_rdata_d;

    logic [SEL_W-1:0]        req_idx_c;
    logic                    sel_ack_c;
    logic [PERI_DATA_W-1:0]  sel_rdata_c;
    logic                    tmo_c;

    assign req_idx_c = reg_addr[ADDR_W-1 -: SEL_W];

    // Only the captured slave's response is visible to the FSM
    always_comb begin : sel_mux
        sel_ack_c   = 1'b0;
        sel_rdata_c = '0;
        for (int unsigned i = 0; i < NUM_SLV; i++) begin
            if (SEL_W'(i) == idx_q) begin
                sel_ack_c   = slv_ack[i];
                sel_rdata_c = slv_rdata[i*PERI_DATA_W +: PERI_DATA_W];
            end
        end
    end

    always_comb begin : fsm_next
        state_d     = state_q;
        idx_d       = idx_q;
        slv_cs_d    = '0;
        slv_wr_d    = slv_wr_q;
        slv_addr_d  = slv_addr_q;
        slv_wdata_d = slv_wdata_q;
        slv_be_d    = slv_be_q;
        reg_ack_d   = 1'b0;
        reg_err_d   = 1'b0;
        reg_rdata_d = '0;
        case (state_q)
            ST_IDLE: begin
                if (reg_cs) begin
                    idx_d       = req_idx_c;
                    slv_wr_d    = reg_wr;
                    slv_addr_d  = reg_addr[SUB_W-1:0];
                    slv_wdata_d = reg_wdata;
                    slv_be_d    = reg_be;
                    if (32'(req_idx_c) < NUM_SLV) begin
                        state_d = ST_ACCESS;
                        for (int unsigned i = 0; i < NUM_SLV; i++) begin
                            slv_cs_d[i] = (SEL_W'(i) == req_idx_c);
                        end
                    end else begin
                        state_d   = ST_RESP;
                        reg_ack_d = 1'b1;
                        reg_err_d = 1'b1;
                    end
                end
            end
            ST_ACCESS: begin
                // Abort beats a same-cycle ack; an ack beats a same-cycle timeout
                if (!reg_cs) begin
                    state_d = ST_IDLE;
                end else if (sel_ack_c) begin
                    state_d     = ST_RESP;
                    reg_ack_d   = 1'b1;
                    reg_rdata_d = slv_wr_q ? '0 : sel_rdata_c;
                end else if (tmo_c) begin
                    state_d     = ST_RESP;
                    reg_ack_d   = 1'b1;
                    reg_err_d   = 1'b1;
                    reg_rdata_d = PERI_TO_DATA;
                end else begin
                    slv_cs_d = slv_cs_q;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge mclk or negedge s_reset_n) begin
        if (!s_reset_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            slv_cs_q    <= '0;
            slv_wr_q    <= 1'b0;
            slv_addr_q  <= '0;
            slv_wdata_q <= '0;
            slv_be_q    <= '0;
            reg_ack_q   <= 1'b0;
            reg_err_q   <= 1'b0;
            reg_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            slv_cs_q    <= slv_cs_d;
            slv_wr_q    <= slv_wr_d;
            slv_addr_q  <= slv_addr_d;
            slv_wdata_q <= slv_wdata_d;
            slv_be_q    <= slv_be_d;
            reg_ack_q   <= reg_ack_d;
            reg_err_q   <= reg_err_d;
            reg_rdata_q <= reg_rdata_d;
        end
    end

`ifdef PERI_TIMEOUT_EN
    logic             wdog_clr_c, wdog_en_c, wdog_expire;
    logic             to_intr_q, to_intr_d;
    logic [SEL_W-1:0] to_slv_id_q, to_slv_id_d;

    // Counter is held clear outside ACCESS so every access starts from zero
    assign wdog_clr_c = (state_q != ST_ACCESS);
    assign wdog_en_c  = (state_q == ST_ACCESS) && !sel_ack_c;
    assign tmo_c      = (state_q == ST_ACCESS) && reg_cs && !sel_ack_c && wdog_expire;

    peri_wdog_cnt #(
        .TO_CYC (TO_CYC)
    ) u_wdog (
        .clk    (mclk),
        .rst_n  (s_reset_n),
        .clr    (wdog_clr_c),
        .en     (wdog_en_c),
        .expire (wdog_expire)
    );

    always_comb begin : tmo_next
        to_intr_d   = tmo_c;
        to_slv_id_d = tmo_c ? idx_q : to_slv_id_q;
    end

    always_ff @(posedge mclk or negedge s_reset_n) begin
        if (!s_reset_n) begin
            to_intr_q   <= 1'b0;
            to_slv_id_q <= '0;
        end else begin
            to_intr_q   <= to_intr_d;
            to_slv_id_q <= to_slv_id_d;
        end
    end

    assign to_intr   = to_intr_q;
    assign to_slv_id = to_slv_id_q;
`else
    assign tmo_c     = 1'b0;
    assign to_intr   = 1'b0;
    assign to_slv_id = '0;
`endif

    assign reg_rdata = reg_rdata_q;
    assign reg_ack   = reg_ack_q;
    assign reg_err   = reg_err_q;
    assign slv_cs    = slv_cs_q;
    assign slv_wr    = slv_wr_q;
    assign slv_addr  = slv_addr_q;
    assign slv_wdata = slv_wdata_q;
    assign slv_be    = slv_be_q;

endmodule
